// File: rtl/jk_latch_driver_if.sv
// rtl/jk_latch_driver_if.sv - target stream handshake between sequencer and JK latch driver
interface jk_latch_driver_if;
  logic tgt_valid;
  logic tgt_bit;
  logic tgt_ready;

  modport master (output tgt_valid, output tgt_bit, input tgt_ready);
  modport slave  (input tgt_valid, input tgt_bit, output tgt_ready);
endinterface

// File: rtl/jk_latch_driver.sv
// rtl/jk_latch_driver.sv - JK latch excitation driver with settle timeout; JK_DRIVER_TOGGLE_EN selects toggle excitation
module jk_latch_driver #(
  parameter int unsigned TIMEOUT_CYCLES = 4,
  parameter int unsigned ERR_CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  jk_latch_driver_if.slave     tgt_if,
  input  logic                 q_fb,
  output logic                 j_out,
  output logic                 k_out,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  input  logic                 err_clr,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_WAIT
  } state_e;

  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e               state_q;
  logic                 target_q;
  logic [7:0]           timer_q;
  logic                 j_q;
  logic                 k_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 err_q;
  logic [ERR_CNT_W-1:0] err_cnt_q;

  logic                 match;
  logic                 j_d;
  logic                 k_d;
  logic [ERR_CNT_W-1:0] err_cnt_d;

  always_comb begin
    match     = (q_fb == target_q);
    err_cnt_d = (&err_cnt_q) ? err_cnt_q : err_cnt_q + 1'b1;
    j_d       = 1'b0;
    k_d       = 1'b0;
    // Excitation is taken from the incoming bit so it can be registered on the accept edge.
    if (q_fb != tgt_if.tgt_bit) begin
`ifdef JK_DRIVER_TOGGLE_EN
      j_d = 1'b1;
      k_d = 1'b1;
`else
      j_d = tgt_if.tgt_bit;
      k_d = ~tgt_if.tgt_bit;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      target_q  <= 1'b0;
      timer_q   <= '0;
      j_q       <= 1'b0;
      k_q       <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      j_q    <= 1'b0;
      k_q    <= 1'b0;
      done_q <= 1'b0;
      // A timeout below overrides this clear on the same edge.
      if (err_clr) begin
        err_q <= 1'b0;
      end
      case (state_q)
        ST_IDLE: begin
          if (tgt_if.tgt_valid) begin
            target_q <= tgt_if.tgt_bit;
            j_q      <= j_d;
            k_q      <= k_d;
            busy_q   <= 1'b1;
            state_q  <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          timer_q <= '0;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (match) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else if (timer_q == TIMER_LAST) begin
            err_q     <= 1'b1;
            err_cnt_q <= err_cnt_d;
            busy_q    <= 1'b0;
            state_q   <= ST_IDLE;
          end else begin
            timer_q <= timer_q + 8'd1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign tgt_if.tgt_ready = (state_q == ST_IDLE);
  assign j_out            = j_q;
  assign k_out            = k_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign err              = err_q;
  assign err_cnt          = err_cnt_q;

endmodule

// File: tb/tb_jk_latch_driver.sv
// tb/tb_jk_latch_driver.sv - self-checking bench for jk_latch_driver with a JK latch model in the loop
module tb_jk_latch_driver;
  localparam int TO = 4;
  localparam int W  = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         q_fb;
  logic         j_out, k_out, busy, done, err, err_clr;
  logic [W-1:0] err_cnt;

  jk_latch_driver_if tif ();

  jk_latch_driver #(.TIMEOUT_CYCLES(TO), .ERR_CNT_W(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .tgt_if  (tif),
    .q_fb    (q_fb),
    .j_out   (j_out),
    .k_out   (k_out),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .err_clr (err_clr),
    .err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  // External JK latch: preloadable, otherwise follows its J/K inputs.
  logic q_lat, lat_load, lat_val, connected, stuck_q;
  always @(posedge clk) begin
    if (lat_load) q_lat <= lat_val;
    else case ({j_out, k_out})
      2'b10:   q_lat <= 1'b1;
      2'b01:   q_lat <= 1'b0;
      2'b11:   q_lat <= ~q_lat;
      default: q_lat <= q_lat;
    endcase
  end
  assign q_fb = connected ? q_lat : stuck_q;

  int vectors = 0;
  int miscompares = 0;
  logic err_m;
  int   cnt_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] exc(input logic t, input logic q);
    if (q == t) return 2'b00;
`ifdef JK_DRIVER_TOGGLE_EN
    return 2'b11;
`else
    return t ? 2'b10 : 2'b01;
`endif
  endfunction

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    err_m = 1'b0;
    chk("err_after_clr", {31'd0, err}, {31'd0, err_m});
    chk("cnt_after_clr", {30'd0, err_cnt}, cnt_m);
  endtask

  // One target: connected latch always settles; a stuck q_fb settles only if it already matches.
  task automatic do_txn(input logic tgt, input logic conn, input logic qi, input logic clr_at_end);
    logic [1:0] ejk;
    logic       match;
    int         lat, n;
    lat_load = 1'b1; lat_val = qi; stuck_q = qi; connected = conn;
    @(negedge clk);
    lat_load = 1'b0;
    n = 0;
    while (!tif.tgt_ready && n < 20) begin @(negedge clk); n++; end
    chk("ready_before", {31'd0, tif.tgt_ready}, 32'd1);
    ejk   = exc(tgt, qi);
    match = conn || (qi == tgt);
    lat   = match ? 2 : 1 + TO;
    tif.tgt_valid = 1'b1; tif.tgt_bit = tgt;
    @(negedge clk);
    tif.tgt_valid = 1'b0;
    chk("drive_jk", {30'd0, j_out, k_out}, {30'd0, ejk});
    chk("drive_busy_ready", {30'd0, busy, tif.tgt_ready}, 32'd2);
    for (int c = 1; c < lat; c++) begin
      @(negedge clk);
      chk("wait_jk_done", {29'd0, j_out, k_out, done}, 32'd0);
      chk("wait_busy", {31'd0, busy}, 32'd1);
    end
    if (clr_at_end) err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    if (!match) begin
      err_m = 1'b1;
      if (cnt_m < (1 << W) - 1) cnt_m++;
    end else if (clr_at_end) err_m = 1'b0;
    chk("end_done", {31'd0, done}, {31'd0, match});
    chk("end_err", {31'd0, err}, {31'd0, err_m});
    chk("end_cnt", {30'd0, err_cnt}, cnt_m);
    chk("end_ready_busy", {30'd0, tif.tgt_ready, busy}, 32'd2);
    @(negedge clk);
    chk("done_one_cycle", {31'd0, done}, 32'd0);
  endtask

  typedef struct {
    logic tgt;
    logic conn;
    logic qi;
    logic clr;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; err_clr = 1'b0; tif.tgt_valid = 1'b0; tif.tgt_bit = 1'b0;
    lat_load = 1'b1; lat_val = 1'b0; connected = 1'b1; stuck_q = 1'b0;
    err_m = 1'b0; cnt_m = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    lat_load = 1'b0;
    @(negedge clk);
    chk("rst_outputs", {26'd0, j_out, k_out, busy, done, err, 1'b0}, 32'd0);
    chk("rst_cnt", {30'd0, err_cnt}, 32'd0);
    chk("rst_ready", {31'd0, tif.tgt_ready}, 32'd1);

    tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b1};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 1'b0};
    tbl[8] = '{1'b0, 1'b0, 1'b1, 1'b0};
    tbl[9] = '{1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 10; i++) begin
      do_txn(tbl[i].tgt, tbl[i].conn, tbl[i].qi, tbl[i].clr);
      if (i == 4) pulse_clr();
    end
    chk("saturated_cnt", {30'd0, err_cnt}, 32'd3);
    pulse_clr();

    // Back-to-back: valid held high, second target taken the cycle after done.
    lat_load = 1'b1; lat_val = 1'b0; connected = 1'b1;
    @(negedge clk);
    lat_load = 1'b0;
    tif.tgt_valid = 1'b1; tif.tgt_bit = 1'b1;
    @(negedge clk);
    chk("b2b_jk1", {30'd0, j_out, k_out}, {30'd0, exc(1'b1, 1'b0)});
    tif.tgt_bit = 1'b0;
    @(negedge clk);
    chk("b2b_wait", {28'd0, busy, tif.tgt_ready, j_out, k_out}, 32'h8);
    @(negedge clk);
    chk("b2b_done1", {30'd0, done, tif.tgt_ready}, 32'd3);
    @(negedge clk);
    tif.tgt_valid = 1'b0;
    chk("b2b_accept2", {29'd0, busy, done, tif.tgt_ready}, 32'd4);
    chk("b2b_jk2", {30'd0, j_out, k_out}, {30'd0, exc(1'b0, 1'b1)});
    repeat (2) @(negedge clk);
    chk("b2b_done2", {31'd0, done}, 32'd1);

    // Reset while waiting on a stuck latch: target dropped, no done/err.
    connected = 1'b0; stuck_q = 1'b0;
    tif.tgt_valid = 1'b1; tif.tgt_bit = 1'b1;
    @(negedge clk);
    tif.tgt_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    err_m = 1'b0; cnt_m = 0;
    chk("midrst_idle", {27'd0, busy, done, err, j_out, k_out}, 32'd0);
    chk("midrst_ready", {31'd0, tif.tgt_ready}, 32'd1);
    for (int i = 0; i < TO + 2; i++) begin
      @(negedge clk);
      chk("midrst_quiet", {29'd0, done, err, busy}, 32'd0);
    end

    for (int i = 0; i < 40; i++) begin
      logic t, cn, q, cl;
      t  = 1'($urandom);
      cn = ($urandom_range(0, 3) != 0);
      q  = 1'($urandom);
      cl = 1'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_txn(t, cn, q, cl);
      if ($urandom_range(0, 4) == 0) pulse_clr();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/jk_latch_driver.md
Name: jk_latch_driver

Overview:
- Initiator-side controller for a JK latch: accepts a stream of target Q values over a valid/ready handshake.
- For each target it computes the J/K excitation from the latch's fed-back Q and drives that excitation for one clock cycle.
- It then waits for Q to settle to the target and reports completion, or a timeout error.
- It sits between a test or control sequencer and any JK latch/flip-flop instance, closing the loop on its Q output.

Parameters:
- TIMEOUT_CYCLES, 4: maximum number of WAIT cycles for q_fb to equal the target before an error is declared; legal range 1..255.
- ERR_CNT_W, 8: width of the saturating error counter.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- tgt_valid  input  1  a target bit is offered.
- tgt_bit  input  1  desired latch Q value.
- tgt_ready  output  1  driver can accept a target; high only in IDLE.
- q_fb  input  1  Q fed back from the driven latch, sampled on clk.
- j_out  output  1  registered J drive to the latch.
- k_out  output  1  registered K drive to the latch.
- busy  output  1  high in DRIVE and WAIT.
- done  output  1  one-cycle pulse: the target was reached.
- err  output  1  sticky timeout flag.
- err_clr  input  1  clears err on the next edge; does not clear err_cnt.
- err_cnt  output  ERR_CNT_W  count of timeouts, saturating at all-ones.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE.
  - j_out=0, k_out=0, busy=0, done=0, err=0, err_cnt=0.
  - Stored target cleared to 0.
  - tgt_ready=1 from the first cycle after reset deasserts.
  - Reset mid-operation drops the in-flight target; no done or err is produced for it.
- States are IDLE, DRIVE, WAIT. j_out and k_out are 0 in every state except DRIVE.
- IDLE:
  - tgt_ready=1.
  - On an edge with tgt_valid=1, latch tgt_bit into target and go to DRIVE.
  - Targets are never queued; tgt_ready=0 outside IDLE.
- DRIVE (exactly 1 cycle), excitation from registered target and q_fb sampled at IDLE->DRIVE edge:
  - q_fb==target -> J=0,K=0 (hold).
  - target=1, q_fb=0 -> J=1,K=0 (set).
  - target=0, q_fb=1 -> J=0,K=1 (reset).
  - Next state is always WAIT; the timer is cleared to 0.
- WAIT (J=K=0):
  - Each edge with q_fb==target: done=1 for exactly the following cycle; go to IDLE.
  - Otherwise increment the timer. When timer==TIMEOUT_CYCLES-1 and there is still no match: set err, increment err_cnt (saturating), go to IDLE; no done.
  - Match on the same edge the timeout would fire: match wins (done, no err).
- Latency, acceptance at edge N:
  - j_out/k_out valid during cycle N..N+1.
  - Earliest done high in cycle N+2..N+3 (q_fb matching at edge N+2).
  - tgt_ready high again in the same cycle done or err is updated.
- err_clr and a timeout on the same edge: err ends set (set wins); err_cnt still increments.
- err_cnt at all-ones: further timeouts leave it unchanged.
- Back-to-back targets: a new target is accepted no earlier than the cycle following done or timeout (minimum 3 cycles per target).

Optional Feature:
- Macro: JK_DRIVER_TOGGLE_EN.
- Defined: when q_fb!=target, DRIVE outputs J=1,K=1 (toggle) instead of set/reset. Hold case unchanged.
- Not defined: set/reset excitation as above; J=K=1 is never driven.

Test Plan:
- Reset held 2 cycles, then released -> j_out=0, k_out=0, done=0, err=0, err_cnt=0; tgt_ready=1 one cycle after release.
- q_fb=0, target 1 accepted at edge N -> j_out=1, k_out=0 for one cycle; model latch sets Q; done pulses exactly one cycle; tgt_ready returns to 1.
- q_fb=1, target 0 -> j_out=0, k_out=1; Q falls; done pulses. Then target 0 again with q_fb=0 -> J=K=0 in DRIVE; done at N+2.
- Model latch disconnected (q_fb stuck 0), target 1, TIMEOUT_CYCLES=4 -> after 4 WAIT cycles err=1, err_cnt=1, no done. Pulse err_clr -> err=0, err_cnt stays 1.
- ERR_CNT_W=2, 5 forced timeouts -> err_cnt saturates at 3. Reset asserted during WAIT -> IDLE next cycle, no done or err.
- With JK_DRIVER_TOGGLE_EN, q_fb=0, target 1 -> j_out=1, k_out=1 for one cycle; without the macro, the same stimulus gives j_out=1, k_out=0.
